// File: rtl/palette_sprite_layer.sv
// Palettized, integer-scaled, multi-frame sprite overlaid on a background pixel stream.
// Optional horizontal mirroring (sprite_flip input) is enabled by defining SPRITE_MIRROR_EN.
module palette_sprite_layer #(
    parameter int IMG_W           = 16,
    parameter int IMG_H           = 16,
    parameter int FRAMES          = 4,
    parameter int SCALE_LOG2      = 1,
    parameter int IDX_W           = 3,
    parameter int ROM_LAT         = 1,
    parameter int TRANSPARENT_IDX = 0,
    localparam int FR_W           = (FRAMES > 1) ? $clog2(FRAMES) : 1,
    localparam int ADDR_W         = $clog2(FRAMES * IMG_W * IMG_H)
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              frame_start,
    input  logic [9:0]        sprite_x,
    input  logic [9:0]        sprite_y,
    input  logic [FR_W-1:0]   sprite_frame,
    input  logic              sprite_en,
`ifdef SPRITE_MIRROR_EN
    input  logic              sprite_flip,
`endif
    output logic [ADDR_W-1:0] rom_address,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pal_index,
    input  logic [3:0]        pal_red,
    input  logic [3:0]        pal_green,
    input  logic [3:0]        pal_blue,
    input  logic [3:0]        bg_red,
    input  logic [3:0]        bg_green,
    input  logic [3:0]        bg_blue,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              hit
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [10:0] SPAN_X = 11'(IMG_W << SCALE_LOG2);
    localparam logic [10:0] SPAN_Y = 11'(IMG_H << SCALE_LOG2);
    localparam logic [IDX_W-1:0] TIDX = IDX_W'(TRANSPARENT_IDX);

    // Shadow copies of the sprite controls, only updated on frame_start
    logic [9:0]      r_sx;
    logic [9:0]      r_sy;
    logic [FR_W-1:0] r_sframe;
    logic            r_sen;
    logic            w_flip;

`ifdef SPRITE_MIRROR_EN
    logic            r_sflip;
    assign w_flip = r_sflip;
`else
    assign w_flip = 1'b0;
`endif

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_sx     <= '0;
            r_sy     <= '0;
            r_sframe <= '0;
            r_sen    <= 1'b0;
`ifdef SPRITE_MIRROR_EN
            r_sflip  <= 1'b0;
`endif
        end else if (frame_start) begin
            r_sx     <= sprite_x;
            r_sy     <= sprite_y;
            r_sframe <= (32'(sprite_frame) < FRAMES) ? sprite_frame : '0;
            r_sen    <= sprite_en;
`ifdef SPRITE_MIRROR_EN
            r_sflip  <= sprite_flip;
`endif
        end
    end

    // Stage 0: signed offsets into the sprite box; bit 10 is the sign
    logic [10:0]       w_rel_x;
    logic [10:0]       w_rel_y;
    logic              w_inside;
    logic [XW-1:0]     w_tex_x;
    logic [YW-1:0]     w_tex_y;
    logic [ADDR_W-1:0] w_addr;

    assign w_rel_x  = {1'b0, DrawX} - {1'b0, r_sx};
    assign w_rel_y  = {1'b0, DrawY} - {1'b0, r_sy};
    assign w_inside = r_sen & blank
                    & ~w_rel_x[10] & (w_rel_x < SPAN_X)
                    & ~w_rel_y[10] & (w_rel_y < SPAN_Y);
    // IMG_W-1-t equals the bitwise inverse of t for a power-of-two width
    assign w_tex_x  = w_rel_x[SCALE_LOG2 +: XW] ^ {XW{w_flip}};
    assign w_tex_y  = w_rel_y[SCALE_LOG2 +: YW];
    assign w_addr   = (ADDR_W'(r_sframe) << (XW + YW))
                    | (ADDR_W'(w_tex_y) << XW)
                    | ADDR_W'(w_tex_x);

    // Address register plus delay line; index ROM_LAT lines up with rom_q
    logic [ADDR_W-1:0] r_rom_address;
    logic [ROM_LAT:0]  r_inside;
    logic [ROM_LAT:0]  r_blank;
    logic [11:0]       r_bg [0:ROM_LAT];

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_rom_address <= '0;
            r_inside      <= '0;
            r_blank       <= '0;
            for (int i = 0; i <= ROM_LAT; i++) begin
                r_bg[i] <= '0;
            end
        end else begin
            r_rom_address <= w_inside ? w_addr : '0;
            r_inside      <= {r_inside[ROM_LAT-1:0], w_inside};
            r_blank       <= {r_blank[ROM_LAT-1:0], blank};
            r_bg[0]       <= {bg_red, bg_green, bg_blue};
            for (int i = 1; i <= ROM_LAT; i++) begin
                r_bg[i] <= r_bg[i-1];
            end
        end
    end

    assign rom_address = r_rom_address;

    logic w_in_a;
    logic w_blank_a;
    assign w_in_a    = r_inside[ROM_LAT];
    assign w_blank_a = r_blank[ROM_LAT];
    assign pal_index = w_in_a ? rom_q : TIDX;

    logic [11:0] r_rgb;
    logic        r_hit;

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_rgb <= '0;
            r_hit <= 1'b0;
        end else if (!w_blank_a) begin
            r_rgb <= '0;
            r_hit <= 1'b0;
        end else if (w_in_a && (rom_q != TIDX)) begin
            r_rgb <= {pal_red, pal_green, pal_blue};
            r_hit <= 1'b1;
        end else begin
            r_rgb <= r_bg[ROM_LAT];
            r_hit <= 1'b0;
        end
    end

    assign red   = r_rgb[11:8];
    assign green = r_rgb[7:4];
    assign blue  = r_rgb[3:0];
    assign hit   = r_hit;

endmodule

// File: tb/tb_palette_sprite_layer.sv
// Directed bench for palette_sprite_layer: a pixel-level reference model predicts
// rom_address and the composited pixel for every driven sample; literals pin the model.
`timescale 1ns/1ps
module tb_palette_sprite_layer;

    localparam int IMG_W = 16, IMG_H = 16, FRAMES = 4, SCALE_LOG2 = 1;
    localparam int IDX_W = 3, ROM_LAT = 1, TRANSPARENT_IDX = 0;
    localparam int LAT   = ROM_LAT + 2;
    localparam int BOX_W = IMG_W << SCALE_LOG2;
    localparam int BOX_H = IMG_H << SCALE_LOG2;
    localparam int PIX   = 1 << SCALE_LOG2;
    localparam int MAXS  = 32768;

    logic       vga_clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] DrawX = '0, DrawY = '0;
    logic       blank = 1'b0, frame_start = 1'b0;
    logic [9:0] sprite_x = '0, sprite_y = '0;
    logic [1:0] sprite_frame = '0;
    logic       sprite_en = 1'b0;
`ifdef SPRITE_MIRROR_EN
    logic       sprite_flip = 1'b0;
`endif
    logic [9:0] rom_address;
    logic [2:0] rom_q;
    logic [2:0] pal_index;
    logic [3:0] pal_red, pal_green, pal_blue;
    logic [3:0] bg_red = '0, bg_green = '0, bg_blue = '0;
    logic [3:0] red, green, blue;
    logic       hit;

    always #5 vga_clk = ~vga_clk;

    palette_sprite_layer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .FRAMES(FRAMES), .SCALE_LOG2(SCALE_LOG2),
        .IDX_W(IDX_W), .ROM_LAT(ROM_LAT), .TRANSPARENT_IDX(TRANSPARENT_IDX)
    ) dut (
        .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .frame_start(frame_start),
        .sprite_x(sprite_x), .sprite_y(sprite_y),
        .sprite_frame(sprite_frame), .sprite_en(sprite_en),
`ifdef SPRITE_MIRROR_EN
        .sprite_flip(sprite_flip),
`endif
        .rom_address(rom_address), .rom_q(rom_q), .pal_index(pal_index),
        .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
        .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
        .red(red), .green(green), .blue(blue), .hit(hit)
    );

    // Sprite ROM with ROM_LAT cycles of read latency, combinational palette
    logic [2:0] rom_mem [0:1023];
    logic [2:0] rom_pipe [0:ROM_LAT-1];
    always @(posedge vga_clk) begin
        rom_pipe[0] <= rom_mem[rom_address];
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_q     = rom_pipe[ROM_LAT-1];
    assign pal_red   = 4'(pal_index) + 4'd5;
    assign pal_green = {pal_index, 1'b1};
    assign pal_blue  = 4'd15 - 4'(pal_index);

    function automatic logic [11:0] pal_rgb(input int idx);
        return {4'(idx + 5), 4'(idx * 2 + 1), 4'(15 - idx)};
    endfunction

    function automatic logic [11:0] bgpat(input int x, input int y);
        return 12'(x * 3 + y * 17);
    endfunction

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state and per-sample expectations, indexed by the capture edge minus one
    int  m_sx = 0, m_sy = 0, m_fr = 0;
    bit  m_en = 0, m_flip = 0;
    logic [9:0]  exp_addr [0:MAXS-1];
    logic [11:0] exp_rgb  [0:MAXS-1];
    bit          exp_hit  [0:MAXS-1];
    bit          exp_v    [0:MAXS-1];
    bit          rst_at   [0:MAXS+7];
    int          ecount = 0;

    always @(posedge vga_clk) begin
        ecount <= ecount + 1;
        rst_at[ecount + 1] <= reset;
    end

    task automatic drive(input int x, input int y, input bit bl, input bit fs,
                         input logic [11:0] bg);
        int s, rx, ry, tx, ty, a, t;
        bit ins;
        s = ecount;
        DrawX = 10'(x); DrawY = 10'(y); blank = bl; frame_start = fs;
        {bg_red, bg_green, bg_blue} = bg;
        if (reset) begin
            m_sx = 0; m_sy = 0; m_fr = 0; m_en = 0; m_flip = 0;
        end
        rx  = x - m_sx;
        ry  = y - m_sy;
        ins = m_en && bl && rx >= 0 && rx < BOX_W && ry >= 0 && ry < BOX_H;
        tx  = rx / PIX;
        ty  = ry / PIX;
        if (m_flip) tx = IMG_W - 1 - tx;
        a   = ins ? (m_fr * IMG_W * IMG_H + ty * IMG_W + tx) : 0;
        t   = int'(rom_mem[a]);
        exp_addr[s] = 10'(a);
        exp_hit[s]  = ins && (t != TRANSPARENT_IDX);
        exp_rgb[s]  = !bl ? 12'h000 : (exp_hit[s] ? pal_rgb(t) : bg);
        exp_v[s]    = 1'b1;
        if (fs && !reset) begin
            m_sx = int'(sprite_x);
            m_sy = int'(sprite_y);
            m_fr = (int'(sprite_frame) < FRAMES) ? int'(sprite_frame) : 0;
            m_en = sprite_en;
`ifdef SPRITE_MIRROR_EN
            m_flip = sprite_flip;
`endif
        end
        @(posedge vga_clk);
        #1;
    endtask

    task automatic px(input int x, input int y);
        drive(x, y, 1'b1, 1'b0, bgpat(x, y));
    endtask

    task automatic line(input int y, input int x0, input int x1, input bit bl);
        for (int x = x0; x <= x1; x++) drive(x, y, bl, 1'b0, bgpat(x, y));
        $display("line y=%0d x=%0d..%0d blank=%0d", y, x0, x1, bl);
    endtask

    task automatic vsync_latch();
        drive(700, 500, 1'b0, 1'b1, 12'h000);
        $display("frame_start sx=%0d sy=%0d frame=%0d en=%0d", sprite_x, sprite_y,
                 sprite_frame, sprite_en);
    endtask

    // Cycle-by-cycle compare against the model
    always @(negedge vga_clk) begin : cmp
        int e, n;
        bit fl;
        e = ecount;
        if (reset) begin
            chk("rst_addr", int'(rom_address), 0);
            chk("rst_rgb", int'({red, green, blue}), 0);
            chk("rst_hit", int'(hit), 0);
        end else begin
            if (e >= 1 && exp_v[e-1])
                chk("addr", int'(rom_address), rst_at[e] ? 0 : int'(exp_addr[e-1]));
            n = e - LAT;
            if (n >= 0 && exp_v[n]) begin
                fl = 1'b0;
                for (int k = n + 1; k <= e; k++) fl = fl | rst_at[k];
                chk("rgb", int'({red, green, blue}), fl ? 0 : int'(exp_rgb[n]));
                chk("hit", int'(hit), fl ? 0 : int'(exp_hit[n]));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        for (int a = 0; a < 1024; a++) rom_mem[a] = 3'((a * 5 + a / 16) % 8);

        repeat (3) drive(0, 0, 1'b0, 1'b0, 12'h000);
        chk("reset_addr", int'(rom_address), 0);
        chk("reset_rgb", int'({red, green, blue}), 0);
        chk("reset_hit", int'(hit), 0);
        reset = 1'b0;

        // No frame_start yet: background pass-through only
        for (int y = 48; y <= 52; y++) begin
            line(y, 0, 639, 1'b1);
            line(y, 640, 659, 1'b0);
        end

        sprite_x = 10'd100; sprite_y = 10'd50; sprite_frame = 2'd0; sprite_en = 1'b1;
        vsync_latch();
        px(99, 50);
        px(100, 50); chk("lit_addr_100_50", int'(rom_address), 0);
        px(101, 50);
        px(102, 50); chk("lit_addr_102_50", int'(rom_address), 1);
        chk("lit_transp_rgb", int'({red, green, blue}), 12'h47E);
        chk("lit_transp_hit", int'(hit), 0);
        px(103, 50);
        px(104, 50);
        chk("lit_opaque_rgb", int'({red, green, blue}), 12'hABA);
        chk("lit_opaque_hit", int'(hit), 1);
        for (int y = 49; y <= 52; y++) line(y, 90, 140, 1'b1);
        for (int y = 80; y <= 83; y++) line(y, 90, 140, 1'b1);
        line(60, 95, 135, 1'b0);
        px(130, 81);
        px(131, 81); chk("lit_addr_131_81", int'(rom_address), 255);

        // Frame select written without frame_start has no effect until latched
        sprite_frame = 2'd3;
        px(100, 50); chk("lit_addr_nolatch", int'(rom_address), 0);
        vsync_latch();
        px(100, 50); chk("lit_addr_frame3", int'(rom_address), 768);
        line(55, 95, 140, 1'b1);

        // frame_start on an active pixel: that pixel still uses the old position
        sprite_x = 10'd110;
        drive(105, 56, 1'b1, 1'b1, bgpat(105, 56));
        line(56, 106, 150, 1'b1);
        line(57, 95, 150, 1'b1);

        // Sprite at the right edge, no wrap to the left edge
        sprite_x = 10'd630; sprite_y = 10'd50; sprite_frame = 2'd1;
        vsync_latch();
        px(630, 50); chk("lit_addr_630_50", int'(rom_address), 256);
        line(60, 600, 639, 1'b1);
        line(60, 640, 659, 1'b0);
        px(0, 61); chk("lit_addr_wrap", int'(rom_address), 0);
        line(61, 1, 30, 1'b1);

        // Asynchronous reset in the middle of a line
        line(62, 600, 633, 1'b1);
        reset = 1'b1;
        #1;
        chk("midrst_rgb", int'({red, green, blue}), 0);
        chk("midrst_hit", int'(hit), 0);
        chk("midrst_addr", int'(rom_address), 0);
        for (int x = 634; x <= 636; x++) px(x, 62);
        reset = 1'b0;
        line(62, 637, 639, 1'b1);
        line(63, 600, 639, 1'b1);

`ifdef SPRITE_MIRROR_EN
        sprite_x = 10'd100; sprite_y = 10'd50; sprite_frame = 2'd0;
        sprite_en = 1'b1; sprite_flip = 1'b1;
        vsync_latch();
        px(100, 50); chk("lit_mirror_100", int'(rom_address), 15);
        px(131, 50); chk("lit_mirror_131", int'(rom_address), 0);
        line(51, 95, 140, 1'b1);
`endif

        repeat (LAT + 2) drive(700, 500, 1'b0, 1'b0, 12'h000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
